// File: rtl/cdc_mcp_arb.sv
// Source-side arbiter/sequencer for one multi-cycle-path CDC channel shared by N requesters.
// One transfer in flight at a time; the next grant waits for the synced ack toggle plus a guard gap.
module cdc_mcp_arb #(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int IDW    = 2,
    parameter int GAP    = 2,
    parameter int TO_CYC = 255
) (
    input  logic                 aclk,
    input  logic                 arst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*DW-1:0]      req_data,
    output logic [N-1:0]         req_ready,
    output logic [IDW+DW-1:0]    tx_data,
    output logic                 tx_en,
    input  logic                 ack_tgl_b,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_spurious
);

    localparam int TW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
    localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);
    localparam logic [TW-1:0]  TO_LAST  = TW'((TO_CYC > 0) ? TO_CYC - 1 : 0);
    localparam logic [TW-1:0]  TO_MAX   = TW'(TO_CYC);
    localparam logic [GW-1:0]  GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(N - 1);

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_IDLE = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_ack_sync;
    logic             w_ack_edge;
    logic [1:0]       r_sync_cnt;
    logic [TW-1:0]    r_to_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   w_gid;
    logic             w_found;
    logic [N-1:0]     w_ready;

    // Requester index k positions after base, wrapping at N (base < N, k < N).
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) begin
            s = s - N;
        end else begin
            s = s;
        end
        return IDW'(s);
    endfunction

    // Three-flop synchronizer for the bclk ack toggle; the last two stages form the edge detect.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_ack_sync <= 3'b000;
        end else begin
            r_ack_sync <= {r_ack_sync[1:0], ack_tgl_b};
        end
    end

    assign w_ack_edge = r_ack_sync[1] ^ r_ack_sync[2];

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req_valid[rr_index(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_gid   = rr_index(r_rr_ptr, k);
            end else begin
                w_found = w_found;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and combinational accept strobe.
    always_comb begin
        w_next  = r_state;
        w_ready = '0;
        case (r_state)
            ST_SYNC: begin
                if (r_sync_cnt == 2'd2) w_next = ST_IDLE;
                else                    w_next = ST_SYNC;
            end
            ST_IDLE: begin
                if (w_found) begin
                    w_next         = ST_SEND;
                    w_ready[w_gid] = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SEND: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_ack_edge) w_next = (GAP == 0) ? ST_IDLE : ST_GAP;
                else            w_next = ST_WAIT;
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) w_next = ST_IDLE;
                else                       w_next = ST_GAP;
            end
            default: begin
                w_next = ST_SYNC;
            end
        endcase
    end

    // A synchronous reset still has to block an accept in the cycle it is asserted.
    assign req_ready = arst ? '0 : w_ready;

    // Counters, grant capture and registered status outputs.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_sync_cnt   <= 2'd0;
            r_to_cnt     <= '0;
            r_gap_cnt    <= '0;
            r_rr_ptr     <= '0;
            tx_data      <= '0;
            tx_en        <= 1'b0;
            busy         <= 1'b1;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            r_sync_cnt   <= (r_state == ST_SYNC) ? r_sync_cnt + 2'd1 : 2'd0;
            tx_en        <= (w_next == ST_SEND);
            busy         <= (w_next != ST_IDLE);
            err_spurious <= w_ack_edge && (r_state inside {ST_IDLE, ST_SEND, ST_GAP});
            err_timeout  <= (TO_CYC != 0) && (r_state == ST_WAIT) && (r_to_cnt == TO_LAST);

            // Saturating at TO_MAX keeps the timeout to a single pulse per transfer.
            if (r_state == ST_SEND) begin
                r_to_cnt <= '0;
            end else if ((r_state == ST_WAIT) && (r_to_cnt != TO_MAX)) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end else begin
                r_to_cnt <= r_to_cnt;
            end

            if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + GW'(1);
            end else begin
                r_gap_cnt <= '0;
            end

            if ((r_state == ST_IDLE) && w_found) begin
                tx_data  <= {w_gid, req_data[int'(w_gid)*DW +: DW]};
                r_rr_ptr <= (w_gid == ID_LAST) ? '0 : w_gid + IDW'(1);
            end else begin
                tx_data  <= tx_data;
                r_rr_ptr <= r_rr_ptr;
            end
        end
    end

endmodule

// File: tb/tb_cdc_mcp_arb.sv
// Self-checking bench for cdc_mcp_arb: directed scenarios plus randomized traffic
// checked against a distance-based round-robin model.
module tb_cdc_mcp_arb;

    localparam int N      = 4;
    localparam int DW     = 8;
    localparam int IDW    = 2;
    localparam int GAP    = 2;
    localparam int TO_CYC = 255;

    logic              aclk = 1'b0;
    logic              arst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [IDW+DW-1:0] tx_data;
    logic              tx_en;
    logic              ack_tgl_b;
    logic              busy;
    logic              err_timeout;
    logic              err_spurious;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;

    cdc_mcp_arb #(.N(N), .DW(DW), .IDW(IDW), .GAP(GAP), .TO_CYC(TO_CYC)) dut (
        .aclk(aclk), .arst(arst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_data(tx_data), .tx_en(tx_en), .ack_tgl_b(ack_tgl_b),
        .busy(busy), .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    always #5 aclk = ~aclk;

    // Winner is the valid requester at the smallest forward distance from the pointer.
    function automatic int model_grant(input logic [N-1:0] v, input int ptr);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            d = (i - ptr + N) % N;
            if (v[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic tick;
        @(posedge aclk);
        #2;
    endtask

    task automatic do_reset;
        int n;
        arst = 1'b1; ack_tgl_b = 1'b0; req_valid = '0;
        tick; tick;
        arst = 1'b0; m_ptr = 0; n = 0;
        while (busy === 1'b1 && n < 20) begin tick; n++; end
    endtask

    task automatic test_reset;
        int n;
        arst = 1'b1; ack_tgl_b = 1'b0; req_valid = '0; req_data = '0;
        tick; tick;
        checks++;
        if (req_ready !== 4'b0 || tx_en !== 1'b0 || tx_data !== 10'h000 || busy !== 1'b1 ||
            err_timeout !== 1'b0 || err_spurious !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: got ready=%b en=%b data=%h busy=%b eto=%b esp=%b exp 0,0,000,1,0,0",
                     req_ready, tx_en, tx_data, busy, err_timeout, err_spurious);
        end
        arst = 1'b0; m_ptr = 0; n = 0;
        while (busy === 1'b1 && n < 20) begin tick; n++; end
        checks++;
        if (n !== 3) begin failures++; $display("FAIL sync_len: got %0d cycles exp 3", n); end
    endtask

    task automatic test_single;
        int n;
        req_data = $urandom;
        req_data[2*DW +: DW] = 8'hA5;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready: got %b exp 0100", req_ready); end
        tick;
        checks++;
        if (tx_en !== 1'b1 || tx_data !== 10'h2A5) begin
            failures++; $display("FAIL single_tx: got en=%b data=%h exp en=1 data=2a5", tx_en, tx_data);
        end
        req_valid = '0;
        tick;
        checks++;
        if (tx_en !== 1'b0) begin failures++; $display("FAIL single_en_width: got %b exp 0", tx_en); end
        ack_tgl_b = ~ack_tgl_b;
        n = 0;
        while (busy === 1'b1 && n < 40) begin tick; n++; end
        checks++;
        if (n !== 3 + GAP) begin failures++; $display("FAIL single_release: got %0d exp %0d", n, 3 + GAP); end
        m_ptr = 3;
    endtask

    task automatic test_round_robin;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int n;
        int bad;
        logic [IDW+DW-1:0] exp_td;
        do_reset;
        req_valid = 4'hF;
        bad = 0;
        for (int j = 0; j < 5; j++) begin
            req_data = $urandom;
            #1;
            n = 0;
            while (req_ready === 4'b0 && n < 20) begin tick; #1; n++; end
            checks++;
            if (req_ready !== (4'b0001 << exp_order[j]) ||
                exp_order[j] !== model_grant(req_valid, m_ptr)) begin
                failures++; $display("FAIL rr_grant%0d: got %b exp %b", j, req_ready, 4'b0001 << exp_order[j]);
            end
            exp_td = {2'(exp_order[j]), req_data[exp_order[j]*DW +: DW]};
            tick;
            checks++;
            if (tx_en !== 1'b1 || tx_data !== exp_td) begin
                failures++; $display("FAIL rr_tx%0d: got en=%b data=%h exp 1 %h", j, tx_en, tx_data, exp_td);
            end
            m_ptr = (exp_order[j] + 1) % N;
            for (int k = 0; k < 6; k++) begin
                tick;
                if (req_ready !== 4'b0 || busy !== 1'b1) bad++;
            end
            ack_tgl_b = ~ack_tgl_b;
        end
        req_valid = '0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin tick; n++; end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL rr_hold: got %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_backpressure;
        int n;
        int first;
        int pulses;
        int bad;
        logic [IDW+DW-1:0] held;
        req_data = $urandom;
        req_valid = 4'b0001;
        #1;
        tick;
        held = {2'd0, req_data[0 +: DW]};
        checks++;
        if (tx_en !== 1'b1 || tx_data !== held) begin
            failures++; $display("FAIL bp_tx: got en=%b data=%h exp 1 %h", tx_en, tx_data, held);
        end
        m_ptr = 1;
        req_valid = 4'hF;
        first = -1; pulses = 0; bad = 0;
        for (int k = 1; k <= TO_CYC + 10; k++) begin
            tick;
            if (err_timeout === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (req_ready !== 4'b0 || busy !== 1'b1 || tx_data !== held) bad++;
        end
        checks++;
        if (pulses !== 1) begin failures++; $display("FAIL to_pulses: got %0d exp 1", pulses); end
        // tx_en cycle, then TO_CYC waiting cycles counted, pulse visible the cycle after.
        checks++;
        if (first !== TO_CYC + 1) begin failures++; $display("FAIL to_time: got %0d exp %0d", first, TO_CYC + 1); end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL bp_hold: got %0d bad cycles exp 0", bad); end
        req_valid = '0;
        ack_tgl_b = ~ack_tgl_b;
        n = 0;
        while (busy === 1'b1 && n < 40) begin tick; n++; end
        checks++;
        if (n !== 3 + GAP) begin failures++; $display("FAIL bp_release: got %0d exp %0d", n, 3 + GAP); end
    endtask

    task automatic test_spurious;
        int first;
        int pulses;
        int bad;
        int g;
        int n;
        ack_tgl_b = ~ack_tgl_b;
        first = -1; pulses = 0; bad = 0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            if (err_spurious === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (busy !== 1'b0) bad++;
        end
        checks++;
        if (first !== 3 || pulses !== 1) begin
            failures++; $display("FAIL spurious_pulse: got at %0d x%0d exp at 3 x1", first, pulses);
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL spurious_state: got %0d busy cycles exp 0", bad); end
        g = $urandom_range(0, N - 1);
        req_data = $urandom;
        req_valid = 4'b0001 << g;
        #1;
        checks++;
        if (req_ready !== (4'b0001 << g)) begin failures++; $display("FAIL post_spur_ready: got %b exp %b", req_ready, 4'b0001 << g); end
        tick;
        checks++;
        if (tx_en !== 1'b1 || tx_data !== {2'(g), req_data[g*DW +: DW]}) begin
            failures++; $display("FAIL post_spur_tx: got en=%b data=%h exp 1 %h", tx_en, tx_data, {2'(g), req_data[g*DW +: DW]});
        end
        m_ptr = (g + 1) % N;
        req_valid = '0;
        tick;
        ack_tgl_b = ~ack_tgl_b;
        n = 0;
        while (busy === 1'b1 && n < 40) begin tick; n++; end
        checks++;
        if (n !== 3 + GAP) begin failures++; $display("FAIL post_spur_release: got %0d exp %0d", n, 3 + GAP); end
    endtask

    task automatic test_drop;
        req_valid = 4'b1000;
        #1;
        req_valid = '0;
        tick;
        checks++;
        if (tx_en !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL drop: got en=%b busy=%b exp 0 0", tx_en, busy);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        int bad;
        req_data = $urandom;
        req_valid = 4'b0010;
        #1;
        tick; tick;
        req_valid = '0;
        tick; tick;
        arst = 1'b1; ack_tgl_b = 1'b0; req_valid = 4'b1010;
        tick;
        arst = 1'b0; m_ptr = 0;
        #1;
        checks++;
        if (tx_en !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0) begin
            failures++; $display("FAIL rstmid_state: got en=%b busy=%b ready=%b exp 0 1 0000", tx_en, busy, req_ready);
        end
        n = 0; bad = 0;
        while (busy === 1'b1 && n < 20) begin
            if (req_ready !== 4'b0) bad++;
            tick; n++;
        end
        checks++;
        if (n !== 3 || bad !== 0) begin failures++; $display("FAIL rstmid_sync: got %0d cycles %0d bad exp 3 0", n, bad); end
        #1;
        checks++;
        if (req_ready !== (4'b0001 << model_grant(req_valid, m_ptr))) begin
            failures++; $display("FAIL rstmid_first: got %b exp 0010", req_ready);
        end
        tick;
        checks++;
        if (tx_data !== {2'd1, req_data[DW +: DW]}) begin
            failures++; $display("FAIL rstmid_tx: got %h exp %h", tx_data, {2'd1, req_data[DW +: DW]});
        end
        m_ptr = 2;
        req_valid = '0;
        tick;
        ack_tgl_b = ~ack_tgl_b;
        n = 0;
        while (busy === 1'b1 && n < 40) begin tick; n++; end
    endtask

    task automatic test_random;
        int g;
        int n;
        int d;
        int bad;
        int errs;
        logic [IDW+DW-1:0] exp_td;
        bad = 0; errs = 0;
        req_valid = 4'($urandom_range(1, 15));
        req_data = $urandom;
        for (int j = 0; j < 40; j++) begin
            #1;
            n = 0;
            while (req_ready === 4'b0 && n < 20) begin tick; #1; n++; end
            g = model_grant(req_valid, m_ptr);
            checks++;
            if (req_ready !== (4'b0001 << g)) begin
                failures++; $display("FAIL rand_grant%0d: got %b exp %b", j, req_ready, 4'b0001 << g);
            end
            exp_td = {2'(g), req_data[g*DW +: DW]};
            tick;
            checks++;
            if (tx_en !== 1'b1 || tx_data !== exp_td) begin
                failures++; $display("FAIL rand_tx%0d: got en=%b data=%h exp 1 %h", j, tx_en, tx_data, exp_td);
            end
            m_ptr = (g + 1) % N;
            req_valid = 4'($urandom_range(1, 15));
            req_data = $urandom;
            d = $urandom_range(1, 8);
            for (int k = 0; k < d; k++) begin
                tick;
                if (req_ready !== 4'b0 || tx_data !== exp_td) bad++;
                if (err_spurious !== 1'b0 || err_timeout !== 1'b0) errs++;
            end
            ack_tgl_b = ~ack_tgl_b;
            #1;
            n = 0;
            while (req_ready === 4'b0 && n < 40) begin
                tick;
                if (err_spurious !== 1'b0 || err_timeout !== 1'b0) errs++;
                n++;
            end
            checks++;
            if (n !== 3 + GAP) begin failures++; $display("FAIL rand_gap%0d: got %0d exp %0d", j, n, 3 + GAP); end
        end
        req_valid = '0;
        checks++;
        if (bad !== 0 || errs !== 0) begin
            failures++; $display("FAIL rand_hold: got %0d bad %0d err cycles exp 0 0", bad, errs);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1; req_valid = '0; req_data = '0; ack_tgl_b = 1'b0;
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_spurious;
        test_drop;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
